nibble_chain_seq: RTL and testbench
===================================

# nibble_chain_seq

Multi-nibble arithmetic/logic sequencer for the risc-4 execute stage. It accepts one chained operation over 1–16 nibbles, streams operand nibble pairs from the nibble register file into the 4-bit ALU one nibble per step (least significant first), and writes each result nibble back. ALU carry/borrow is propagated between nibbles, and the final carry and an aggregate zero flag are reported. The ALU is instantiated alongside this block in the execute wrapper and is not inside it.

## Interface
- No parameters. Nibble width is 4, register file depth is 16, and the length field is 4 bits; these are package constants.
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid & req_ready
- req_op  in  4  ALU op code: ADD=0, ADC=1, SUB=2, SBB=3, AND=4, OR=5, XOR=6; all other codes are illegal
- req_len  in  4  nibble count; 0 means 16
- req_src_a, req_src_b, req_dst  in  4 each  base register addresses
- req_carry  in  1  initial carry/borrow, used only for ADC/SBB
- rf_raddr_a, rf_raddr_b  out  4 each  register file read addresses; synchronous read, 1-cycle latency
- rf_rdata_a, rf_rdata_b  in  4 each  read data
- rf_we  out  1; rf_waddr  out  4; rf_wdata  out  4  write port; write takes effect at the clock edge
- alu_operand_a, alu_operand_b  out  4 each; alu_op  out  4; alu_carry_in  out  1  ALU drive
- alu_result  in  4; alu_carry_out  in  1; alu_zero  in  1  ALU response, combinational
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 means the op was illegal
- flag_carry  out  1  final carry/borrow; holds until the next done
- flag_zero  out  1  1 if every result nibble was zero; holds until the next done

## Operation
- States: IDLE, RD, EX, FIN.
- **IDLE.** On accept, latch op, len, the three addresses, carry, and index i=0.
  - Legal op: go to RD, with carry register set to req_carry for ADC/SBB and 0 otherwise, and zero accumulator set to 1.
  - Illegal op: go to FIN with err pending.
- **RD.** Drive rf_raddr_a = src_a+i and rf_raddr_b = src_b+i, both mod 16. Go to EX.
- **EX.** ALU operands are rf_rdata_a and rf_rdata_b.
  - alu_op: the latched op on nibble 0. For nibble i>0, ADD→ADC and SUB→SBB; logic ops are unchanged.
  - alu_carry_in: the carry register for arithmetic ops, 0 for logic ops.
  - Assert rf_we with rf_waddr = dst+i (mod 16) and rf_wdata = alu_result.
  - Capture carry register ← alu_carry_out (0 for logic ops). Zero accumulator &= alu_zero. Increment i.
  - If i was the last nibble, go to FIN; otherwise go to RD.
- **FIN.** Pulse done.
  - Legal op: flag_carry ← carry register, flag_zero ← accumulator, err=0.
  - Illegal op: err=1 and flags unchanged. No rf reads are meaningful and rf_we is never asserted.
  - Go to IDLE.
- For SUB/SBB, carry is borrow: 1 means the A chain is smaller than the B chain.
- Overlapping src/dst is allowed. The write of nibble i lands before the read of nibble i+1, so later reads see updated values.
- Address arithmetic wraps mod 16. Nibble count 16 with src=dst touches every register exactly once.
- When not in EX: alu_op, alu_carry_in and the ALU operands are driven 0, and rf_we=0.

## Timing
- Accept in cycle 0.
  - Nibble k: RD in cycle 2k+1, EX in cycle 2k+2.
  - done in cycle 2L+1, where L is the decoded length.
  - req_ready returns high in cycle 2L+2.
- Illegal op: done=err=1 in cycle 1.
- Throughput: one nibble per 2 cycles. No back-to-back overlap between requests.
- Reset values:
  - State IDLE, so req_ready=1.
  - done=0, err=0, rf_we=0, flag_carry=0, flag_zero=0.
  - All address and ALU drive outputs are 0.
- Reset mid-operation aborts immediately. No further rf_we and no done. Register file contents already written stay written.
- req_valid while busy is ignored; the requester must hold it until ready.

## Structure
- The shared package risc4_pkg holds:
  - alu_op_t with the ALU op codes, shared with the ALU.
  - Nibble width and register file depth constants.
  - seq_state_t {IDLE, RD, EX, FIN}.
  - The helper that maps ADD/SUB to ADC/SBB for i>0.
- Single flat module; no sub-module is warranted.

## Test plan
- ADD, L=2, A@0..1={F,2}, B@2..3={1,0}, dst 4 → R4=0, R5=3, flag_carry=0, flag_zero=0, done at cycle 5.
- SUB, L=2, A={0,0}, B={1,0} → dst nibbles {F,F}, flag_carry=1 (borrow), flag_zero=0.
- ADC, L=1, A=F, B=0, req_carry=1 → result 0, flag_carry=1, flag_zero=1.
- L=0 (16 nibbles), src_a=14 → reads wrap 14,15,0..13; 16 rf_we pulses; done at cycle 33.
- req_op=7 → done=err=1 at cycle 1, rf_we never asserted, flags hold their prior values.
- ADD L=4, rst asserted in cycle 3 → exactly one rf_we seen (cycle 2), no done, req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/nibble_chain_seq_pkg.sv
// Shared risc-4 execute-stage types: ALU op codes, nibble/register-file sizing,
// the chain sequencer state encoding and the ALU op chaining helper.
package risc4_pkg;

    localparam int NIB_W    = 4;
    localparam int RF_DEPTH = 16;
    localparam int ADDR_W   = $clog2(RF_DEPTH);
    localparam int LEN_W    = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBB = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        EX   = 2'd2,
        FIN  = 2'd3
    } seq_state_t;

    function automatic logic op_legal(input logic [3:0] code);
        return code <= 4'd6;
    endfunction

    function automatic logic is_arith(input alu_op_t op);
        return op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBB};
    endfunction

    function automatic logic uses_carry_in(input alu_op_t op);
        return op inside {OP_ADC, OP_SBB};
    endfunction

    // Nibbles after the first must consume the carry/borrow of the previous one.
    function automatic alu_op_t chain_op(input alu_op_t op, input logic first);
        if (first)
            return op;
        case (op)
            OP_ADD:  return OP_ADC;
            OP_SUB:  return OP_SBB;
            default: return op;
        endcase
    endfunction

endpackage

// File: rtl/nibble_chain_seq_if.sv
// Request, register-file and ALU signal bundle for the nibble chain sequencer.
// slave = the sequencer, master = requester / register file / ALU side.
interface nibble_chain_seq_if;
    import risc4_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [LEN_W-1:0]  req_len;
    logic [ADDR_W-1:0] req_src_a;
    logic [ADDR_W-1:0] req_src_b;
    logic [ADDR_W-1:0] req_dst;
    logic              req_carry;

    logic [ADDR_W-1:0] rf_raddr_a;
    logic [ADDR_W-1:0] rf_raddr_b;
    logic [NIB_W-1:0]  rf_rdata_a;
    logic [NIB_W-1:0]  rf_rdata_b;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [NIB_W-1:0]  rf_wdata;

    logic [NIB_W-1:0]  alu_operand_a;
    logic [NIB_W-1:0]  alu_operand_b;
    logic [3:0]        alu_op;
    logic              alu_carry_in;
    logic [NIB_W-1:0]  alu_result;
    logic              alu_carry_out;
    logic              alu_zero;

    logic              done;
    logic              err;
    logic              flag_carry;
    logic              flag_zero;

    modport slave (
        input  req_valid, req_op, req_len, req_src_a, req_src_b, req_dst, req_carry,
        output req_ready,
        output rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
        input  rf_rdata_a, rf_rdata_b,
        output alu_operand_a, alu_operand_b, alu_op, alu_carry_in,
        input  alu_result, alu_carry_out, alu_zero,
        output done, err, flag_carry, flag_zero
    );

    modport master (
        output req_valid, req_op, req_len, req_src_a, req_src_b, req_dst, req_carry,
        input  req_ready,
        input  rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
        output rf_rdata_a, rf_rdata_b,
        input  alu_operand_a, alu_operand_b, alu_op, alu_carry_in,
        output alu_result, alu_carry_out, alu_zero,
        input  done, err, flag_carry, flag_zero
    );

endinterface

// File: rtl/nibble_chain_seq.sv
// Multi-nibble ALU sequencer: streams operand nibble pairs from the register file
// through the external 4-bit ALU, LSB first, chaining carry/borrow and writing back.
module nibble_chain_seq
    import risc4_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    nibble_chain_seq_if.slave  bus
);

    seq_state_t        state_q, state_d;
    alu_op_t           op_q;
    logic              illegal_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
    logic [LEN_W-1:0]  idx_q;
    logic              carry_q;
    logic              zacc_q;
    logic              flag_c_q, flag_z_q;

    logic accept;
    logic last_nib;

    assign accept   = bus.req_valid && (state_q == IDLE);
    // len 0 encodes 16 nibbles; the 4-bit decrement wraps it to index 15.
    assign last_nib = (idx_q == len_q - 4'd1);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = op_legal(bus.req_op) ? RD : FIN;
            RD:   state_d = EX;
            EX:   state_d = last_nib ? FIN : RD;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_ADD;
            illegal_q <= 1'b0;
            len_q     <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            dst_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            zacc_q    <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q      <= alu_op_t'(bus.req_op);
                    illegal_q <= !op_legal(bus.req_op);
                    len_q     <= bus.req_len;
                    src_a_q   <= bus.req_src_a;
                    src_b_q   <= bus.req_src_b;
                    dst_q     <= bus.req_dst;
                    idx_q     <= '0;
                    carry_q   <= uses_carry_in(alu_op_t'(bus.req_op)) & bus.req_carry;
                    zacc_q    <= 1'b1;
                end
                EX: begin
                    carry_q <= is_arith(op_q) & bus.alu_carry_out;
                    zacc_q  <= zacc_q & bus.alu_zero;
                    idx_q   <= idx_q + 4'd1;
                end
                FIN: if (!illegal_q) begin
                    flag_c_q <= carry_q;
                    flag_z_q <= zacc_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready     = (state_q == IDLE);
        bus.rf_raddr_a    = '0;
        bus.rf_raddr_b    = '0;
        bus.rf_we         = 1'b0;
        bus.rf_waddr      = '0;
        bus.rf_wdata      = '0;
        bus.alu_operand_a = '0;
        bus.alu_operand_b = '0;
        bus.alu_op        = '0;
        bus.alu_carry_in  = 1'b0;
        bus.done          = 1'b0;
        bus.err           = 1'b0;
        // Flags show the new result during the done pulse and hold afterwards.
        bus.flag_carry    = flag_c_q;
        bus.flag_zero     = flag_z_q;
        case (state_q)
            RD: begin
                bus.rf_raddr_a = src_a_q + idx_q;
                bus.rf_raddr_b = src_b_q + idx_q;
            end
            EX: begin
                bus.alu_operand_a = bus.rf_rdata_a;
                bus.alu_operand_b = bus.rf_rdata_b;
                bus.alu_op        = chain_op(op_q, idx_q == '0);
                bus.alu_carry_in  = is_arith(op_q) & carry_q;
                bus.rf_we         = 1'b1;
                bus.rf_waddr      = dst_q + idx_q;
                bus.rf_wdata      = bus.alu_result;
            end
            FIN: begin
                bus.done = 1'b1;
                bus.err  = illegal_q;
                if (!illegal_q) begin
                    bus.flag_carry = carry_q;
                    bus.flag_zero  = zacc_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nibble_chain_seq.sv
// Directed bench for nibble_chain_seq with a register-file and ALU model; expected
// completions and write-backs are queued by the driver and checked by a monitor.
module tb_nibble_chain_seq;
    import risc4_pkg::*;

    typedef struct {
        int   cyc;
        logic err;
        logic c;
        logic z;
    } done_exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [3:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    done_exp_t done_q[$];
    wr_exp_t   wr_q[$];

    logic [3:0] mem [16];
    logic [3:0] init_mem [16];
    logic       load = 1'b0;

    nibble_chain_seq_if bus();

    nibble_chain_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: synchronous read, write at the edge.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
        end else if (bus.rf_we) begin
            mem[bus.rf_waddr] <= bus.rf_wdata;
        end
        bus.rf_rdata_a <= mem[bus.rf_raddr_a];
        bus.rf_rdata_b <= mem[bus.rf_raddr_b];
    end

    // 4-bit ALU reference.
    always_comb begin
        logic [4:0] t;
        t = '0;
        case (bus.alu_op)
            4'd0: t = {1'b0, bus.alu_operand_a} + {1'b0, bus.alu_operand_b};
            4'd1: t = {1'b0, bus.alu_operand_a} + {1'b0, bus.alu_operand_b} + {4'd0, bus.alu_carry_in};
            4'd2: t = {1'b0, bus.alu_operand_a} - {1'b0, bus.alu_operand_b};
            4'd3: t = {1'b0, bus.alu_operand_a} - {1'b0, bus.alu_operand_b} - {4'd0, bus.alu_carry_in};
            4'd4: t = {1'b0, bus.alu_operand_a & bus.alu_operand_b};
            4'd5: t = {1'b0, bus.alu_operand_a | bus.alu_operand_b};
            4'd6: t = {1'b0, bus.alu_operand_a ^ bus.alu_operand_b};
            default: t = '0;
        endcase
        bus.alu_result    = t[3:0];
        bus.alu_carry_out = t[4];
        bus.alu_zero      = (t[3:0] == 4'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done and every rf write must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    done_exp_t e;
                    e = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("err", 32'(bus.err), 32'(e.err));
                    chk("flag_carry", 32'(bus.flag_carry), 32'(e.c));
                    chk("flag_zero", 32'(bus.flag_zero), 32'(e.z));
                end
            end
            if (bus.rf_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_rf_we", 32'(bus.rf_we), 32'd0);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    chk("wr_cycle", 32'(cyc), 32'(w.cyc));
                    chk("wr_addr", 32'(bus.rf_waddr), 32'(w.addr));
                    chk("wr_data", 32'(bus.rf_wdata), 32'(w.data));
                end
            end
        end
    end

    task automatic load_mem();
        @(negedge clk);
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] len, input logic [3:0] sa,
                         input logic [3:0] sb, input logic [3:0] d, input logic cin,
                         output int t0);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(n), 32'd0);
        bus.req_op    = op;
        bus.req_len   = len;
        bus.req_src_a = sa;
        bus.req_src_b = sb;
        bus.req_dst   = d;
        bus.req_carry = cin;
        bus.req_valid = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic push_done(input int c, input logic e, input logic fc, input logic fz);
        done_exp_t x;
        x.cyc = c; x.err = e; x.c = fc; x.z = fz;
        done_q.push_back(x);
    endtask

    task automatic push_wr(input int c, input logic [3:0] a, input logic [3:0] v);
        wr_exp_t x;
        x.cyc = c; x.addr = a; x.data = v;
        wr_q.push_back(x);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((done_q.size() != 0 || wr_q.size() != 0 || !bus.req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(done_q.size() + wr_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int t0;
        logic [3:0] res16 [16];
        bus.req_valid = 1'b0;
        bus.req_op = '0; bus.req_len = '0; bus.req_src_a = '0;
        bus.req_src_b = '0; bus.req_dst = '0; bus.req_carry = 1'b0;
        for (int i = 0; i < 16; i++) init_mem[i] = 4'd0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_flags", 32'({bus.flag_carry, bus.flag_zero}), 32'd0);
        chk("rst_raddr", 32'({bus.rf_raddr_a, bus.rf_raddr_b, bus.rf_waddr}), 32'd0);
        chk("rst_alu_drive", 32'({bus.alu_op, bus.alu_carry_in, bus.alu_operand_a, bus.alu_operand_b}), 32'd0);

        // ADD L=2: F2 + 01 = 03 (no final carry)
        init_mem[0] = 4'hF; init_mem[1] = 4'h2; init_mem[2] = 4'h1; init_mem[3] = 4'h0;
        load_mem();
        issue(4'd0, 4'd2, 4'd0, 4'd2, 4'd4, 1'b0, t0);
        push_wr(t0 + 2, 4'd4, 4'h0);
        push_wr(t0 + 4, 4'd5, 4'h3);
        push_done(t0 + 5, 1'b0, 1'b0, 1'b0);
        drain("add_drain");

        // SUB L=2: 00 - 01 = FF with borrow
        init_mem[0] = 4'h0; init_mem[1] = 4'h0; init_mem[2] = 4'h1; init_mem[3] = 4'h0;
        load_mem();
        issue(4'd2, 4'd2, 4'd0, 4'd2, 4'd4, 1'b0, t0);
        push_wr(t0 + 2, 4'd4, 4'hF);
        push_wr(t0 + 4, 4'd5, 4'hF);
        push_done(t0 + 5, 1'b0, 1'b1, 1'b0);
        drain("sub_drain");

        // ADC L=1: F + 0 + 1 = 0 carry 1, zero
        init_mem[0] = 4'hF; init_mem[2] = 4'h0;
        load_mem();
        issue(4'd1, 4'd1, 4'd0, 4'd2, 4'd4, 1'b1, t0);
        push_wr(t0 + 2, 4'd4, 4'h0);
        push_done(t0 + 3, 1'b0, 1'b1, 1'b1);
        drain("adc_drain");

        // Illegal op: err in cycle 1, flags keep the ADC result, no writes
        issue(4'd7, 4'd3, 4'd0, 4'd2, 4'd4, 1'b0, t0);
        push_done(t0 + 1, 1'b1, 1'b1, 1'b1);
        drain("illegal_drain");
        chk("illegal_hold_carry", 32'(bus.flag_carry), 32'd1);
        chk("illegal_hold_zero", 32'(bus.flag_zero), 32'd1);

        // OR, 16 nibbles, src_a=14 wraps, dst=14 overlaps A
        for (int i = 0; i < 16; i++) init_mem[i] = 4'h0;
        init_mem[15] = 4'h5; init_mem[3] = 4'hA;
        load_mem();
        for (int i = 0; i < 16; i++) res16[i] = 4'h0;
        res16[1] = 4'h5; res16[3] = 4'hA; res16[5] = 4'hA; res16[15] = 4'h5;
        issue(4'd5, 4'd0, 4'd14, 4'd0, 4'd14, 1'b1, t0);
        for (int i = 0; i < 16; i++) push_wr(t0 + 2 + 2 * i, 4'(14 + i), res16[i]);
        push_done(t0 + 33, 1'b0, 1'b0, 1'b0);
        drain("len16_drain");

        // ADD L=4 aborted by reset in cycle 3: one write in cycle 2, no done
        init_mem[0] = 4'h3; init_mem[2] = 4'h4;
        load_mem();
        issue(4'd0, 4'd4, 4'd0, 4'd2, 4'd8, 1'b0, t0);
        push_wr(t0 + 2, 4'd8, 4'h7);
        while (cyc < t0 + 3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_flags", 32'({bus.flag_carry, bus.flag_zero}), 32'd0);
        repeat (20) @(negedge clk);
        chk("abort_queues_empty", 32'(done_q.size() + wr_q.size()), 32'd0);
        chk("abort_mem_r8", 32'(mem[8]), 32'h7);
        chk("abort_mem_r9", 32'(mem[9]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
